// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control core.
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} sw_state_t;
  typedef logic [3:0] bcd_t;

  localparam int unsigned DIGIT_MAX_DEC = 9;
  localparam int unsigned DIGIT_MAX_SEX = 5;
  localparam int          NUM_DIGITS    = 8;

  // Digit order is c1,c10,s1,s10,m1,m10,h1,h10; only the tens of seconds and minutes stop at 5.
  function automatic int unsigned digit_max(input int idx);
    return (idx == 3 || idx == 5) ? DIGIT_MAX_SEX : DIGIT_MAX_DEC;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the carry chain; counts 0..MAX and carries when it wraps.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = DIGIT_MAX_DEC
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic carry_in,
  input  logic hold,
  output bcd_t q,
  output logic carry_out
);

  localparam bcd_t QMAX = bcd_t'(MAX);

  logic at_max;

  assign at_max    = (q == QMAX);
  assign carry_out = carry_in & at_max;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      q <= '0;
    end else if (carry_in && !hold) begin
      q <= at_max ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap control and HH:MM:SS.hh BCD timekeeping.
// Optional lap feature is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter bit SATURATE               = 1'b1,
  parameter bit TICK_IS_REQUIRED_PULSE = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  input  logic        tick,
  output logic [31:0] display_value,
  output logic        timer_run,
  output logic        timer_clear,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);

  sw_state_t                   state, next_state;
  logic                        tick_evt;
  logic                        counting;
  logic                        clear_ev, ss_ev;
  logic                        hold;
  logic [NUM_DIGITS:0]         carry;
  logic [4*NUM_DIGITS-1:0]     live;

  generate
    if (TICK_IS_REQUIRED_PULSE) begin : g_tick_raw
      assign tick_evt = tick;
    end else begin : g_tick_edge
      logic tick_q;
      always_ff @(posedge clock) begin
        if (reset) tick_q <= 1'b0;
        else       tick_q <= tick;
      end
      assign tick_evt = tick & ~tick_q;
    end
  endgenerate

  // clear is only meaningful while stopped, and then it outranks start_stop.
  assign clear_ev = clear & (state == IDLE || state == PAUSE);
  assign ss_ev    = start_stop & ~clear_ev;
  assign counting = (state == RUN) || (state == LAP);

`ifdef STOPWATCH_LAP_EN
  logic                    lap_ev;
  logic [4*NUM_DIGITS-1:0] snapshot;

  assign lap_ev = lap & ~start_stop & counting;

  always_ff @(posedge clock) begin
    if (reset)                        snapshot <= '0;
    else if (lap_ev && state == RUN)  snapshot <= live;
  end
`else
  logic unused_lap;
  assign unused_lap = lap;
`endif

  // Counter chain: the top carry means the count sits at 99:59:59.99 and is ticking.
  assign carry[0] = tick_evt & counting;
  assign hold     = SATURATE & carry[NUM_DIGITS];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_counter #(
      .MAX(digit_max(i))
    ) u_cnt (
      .clock    (clock),
      .reset    (reset),
      .clr      (clear_ev),
      .carry_in (carry[i]),
      .hold     (hold),
      .q        (live[4*i +: 4]),
      .carry_out(carry[i+1])
    );
  end

  always_ff @(posedge clock) begin
    if (reset)                  overflow <= 1'b0;
    else if (clear_ev)          overflow <= 1'b0;
    else if (carry[NUM_DIGITS]) overflow <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (ss_ev) next_state = RUN;
      RUN: begin
        if (ss_ev) next_state = PAUSE;
`ifdef STOPWATCH_LAP_EN
        else if (lap_ev) next_state = LAP;
`endif
      end
      PAUSE: begin
        if (clear_ev)   next_state = IDLE;
        else if (ss_ev) next_state = RUN;
      end
`ifdef STOPWATCH_LAP_EN
      LAP: begin
        if (ss_ev)       next_state = PAUSE;
        else if (lap_ev) next_state = RUN;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    timer_run     = 1'b0;
    running       = 1'b0;
    lap_active    = 1'b0;
    display_value = live;
    case (state)
      RUN: begin
        timer_run = 1'b1;
        running   = 1'b1;
      end
`ifdef STOPWATCH_LAP_EN
      LAP: begin
        timer_run     = 1'b1;
        running       = 1'b1;
        lap_active    = 1'b1;
        display_value = snapshot;
      end
`endif
      default: ;
    endcase
    // Restart the prescaler whenever counting (re)starts or the count is zeroed.
    timer_clear = (state == IDLE || state == PAUSE) && (start_stop || clear);
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control and timekeeping core of the stopwatch. It takes debounced single-cycle button pulses (start/stop, lap, clear) and a 10 ms tick from the prescaler. It runs the run/pause/lap state machine and keeps an 8-digit BCD count in HH:MM:SS.hh format. Its packed digit word drives the eight digit inputs of the seven-segment display, and it tells the prescaler when to count and when to restart.

Parameters:
SATURATE, 1, 1 = hold at 99:59:59.99 on overflow; 0 = wrap to 00:00:00.00
TICK_IS_REQUIRED_PULSE, 1, 1 = tick is guaranteed one cycle wide (no edge detect); 0 = rising-edge detect on tick internally

Ports:
clock  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
start_stop  input  1  one-cycle pulse: toggles run/pause
lap  input  1  one-cycle pulse: freeze/unfreeze display while counting
clear  input  1  one-cycle pulse: zero the count when stopped
tick  input  1  10 ms enable from prescaler
display_value  output  32  {h10,h1,m10,m1,s10,s1,c10,c1}, 4 bits each, digit1 = [3:0]
timer_run  output  1  high in RUN and LAP; prescaler counts only when high
timer_clear  output  1  one-cycle restart pulse to the prescaler
running  output  1  high in RUN and LAP
lap_active  output  1  high in LAP
overflow  output  1  sticky: count passed 99:59:59.99

Behaviour:
- One clock domain. Reset is synchronous and active-high. The clock and reset ports are named clock and reset.
- Reset values: state = IDLE, all BCD digits = 0, snapshot = 0, display_value = 32'h0. timer_run, timer_clear, running, lap_active and overflow are all 0.
- States:
  - IDLE: zeroed, stopped.
  - RUN: counting, live display.
  - PAUSE: stopped, count held.
  - LAP: counting, display frozen.
- Input priority when several pulses arrive in the same cycle: clear > start_stop > lap. Only the highest-priority valid event is acted on.
- Transitions take effect at the next edge:
  - IDLE + start_stop -> RUN
  - RUN + start_stop -> PAUSE
  - RUN + lap -> LAP; the snapshot captures the current pre-increment count at that edge.
  - LAP + lap -> RUN
  - LAP + start_stop -> PAUSE; the display returns to the live count.
  - PAUSE + start_stop -> RUN
  - PAUSE + clear -> IDLE; the count is zeroed and overflow is cleared.
  - IDLE + clear -> IDLE, with no other effect.
- Ignored inputs:
  - clear in RUN or LAP.
  - lap in IDLE or PAUSE.
- Counting:
  - Digits increment on an edge where tick = 1 and the registered state is RUN or LAP.
  - A tick in the same cycle as the start_stop that leaves IDLE or PAUSE is not counted.
  - A tick in the same cycle as the start_stop that enters PAUSE is counted.
- BCD carry chain: c1 0-9 -> c10 0-9 -> s1 0-9 -> s10 0-5 -> m1 0-9 -> m10 0-5 -> h1 0-9 -> h10 0-9.
  - A digit carries only when its own carry-in is set and it is at its maximum.
  - No digit ever holds a non-BCD value or exceeds its maximum.
- Overflow, on a tick at 99:59:59.99:
  - SATURATE = 1: all digits hold and overflow is set.
  - SATURATE = 0: all digits go to 0 and overflow is set.
  - overflow stays set until clear-in-PAUSE or reset.
- Display and status timing:
  - display_value = snapshot in LAP, otherwise the live digits.
  - display_value is combinational from registers, so there is zero extra latency after the counting edge.
- timer_clear:
  - Combinational; high in the cycle start_stop is accepted in IDLE or PAUSE, or clear is accepted.
  - The prescaler therefore restarts and the first 10 ms after a start is full length.
- timer_run, running and lap_active decode directly from the registered state.
- Reset mid-run returns everything to the reset values on the next edge, regardless of other inputs.

Optional Feature:
STOPWATCH_LAP_EN
- Defined: the LAP state, the snapshot register and the lap input behave as above.
- Undefined:
  - The lap input is ignored, the LAP state and snapshot register are not built, and lap_active is tied to 0.
  - display_value is always the live digits.
  - All other behaviour is unchanged.

Decomposition:
- stopwatch_pkg holds:
  - the state enum sw_state_t {IDLE, RUN, PAUSE, LAP};
  - typedef bcd_t = logic [3:0];
  - the constants DIGIT_MAX_DEC = 9 and DIGIT_MAX_SEX = 5;
  - the constant NUM_DIGITS = 8.
- One sub-module is natural: bcd_digit_counter.
  - Parameter MAX.
  - Ports: clock, reset, clr, carry_in, hold, q, carry_out.
  - Instantiated 8 times in a chain.
  - The hold input implements saturation.

Test Plan:
1. Reset, then start_stop; apply 100 ticks -> display_value = 32'h0000_0100; timer_clear pulses once; running = 1.
2. Preload via 5999 ticks (00:00:59.99), then 1 tick -> 32'h0000_0100_00 pattern {00,01,00,00}, i.e. display_value = 32'h0001_0000.
3. In RUN at 32'h0000_0250, send lap, then 30 ticks -> display holds 32'h0000_0250 and lap_active = 1. Send lap again -> display shows 32'h0000_0280.
4. Pause at 32'h0000_0042, then 10 ticks -> display stays 32'h0000_0042. Send clear -> 32'h0; state IDLE; timer_clear pulses. A clear sent in RUN has no effect.
5. Force 99:59:59.99 (32'h9959_5999), then 1 tick:
   - SATURATE = 1 -> display stays 32'h9959_5999 and overflow = 1.
   - SATURATE = 0 -> display = 32'h0 and overflow = 1.
   - Clear in PAUSE -> overflow = 0.
6. start_stop, lap and tick in the same cycle in IDLE -> RUN entered, lap ignored, count stays 32'h0. Then reset asserted mid-RUN -> all outputs 0 on the next edge.
